// File: rtl/register_file.sv
// Register file with a registered operand stage: two read ports captured into
// rda/rdb, one write port, write-through bypass and stall-time operand refresh.
module register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              wen,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rda,
  output logic [DATA_W-1:0] rdb
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rda_q, rda_d;
  logic [DATA_W-1:0] rdb_q, rdb_d;
  logic [ADDR_W-1:0] held1_q, held1_d;
  logic [ADDR_W-1:0] held2_q, held2_d;

  logic              wr_hit_c;
  logic [DATA_W-1:0] rf_rs1_c;
  logic [DATA_W-1:0] rf_rs2_c;

  // x0 is hardwired: it never accepts a write and always reads back as zero.
  assign wr_hit_c = wen && (rd != '0);
  assign rf_rs1_c = (rs1 == '0) ? '0 : regs_q[rs1];
  assign rf_rs2_c = (rs2 == '0) ? '0 : regs_q[rs2];

  // Operand stage next state: capture with bypass, or hold with refresh on stall.
  always_comb begin
    rda_d   = rda_q;
    rdb_d   = rdb_q;
    held1_d = held1_q;
    held2_d = held2_q;
    if (en) begin
      held1_d = rs1;
      held2_d = rs2;
      rda_d   = (wr_hit_c && (rd == rs1)) ? wdata : rf_rs1_c;
      rdb_d   = (wr_hit_c && (rd == rs2)) ? wdata : rf_rs2_c;
    end else begin
      if (wr_hit_c && (rd == held1_q)) rda_d = wdata;
      if (wr_hit_c && (rd == held2_q)) rdb_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      rda_q   <= '0;
      rdb_q   <= '0;
      held1_q <= '0;
      held2_q <= '0;
    end else begin
      if (wr_hit_c) regs_q[rd] <= wdata;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      held1_q <= held1_d;
      held2_q <= held2_d;
    end
  end

  assign rda = rda_q;
  assign rdb = rdb_q;

endmodule

// File: tb/tb_register_file.sv
// Directed and randomized bench for register_file against a behavioural model
// that applies each write first and then reads the tracked register.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [31:0] rda;
  logic [31:0] rdb;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_rda;
  logic [31:0] m_rdb;
  logic [4:0]  m_h1;
  logic [4:0]  m_h2;

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .rs1   (rs1),
    .rs2   (rs2),
    .wen   (wen),
    .rd    (rd),
    .wdata (wdata),
    .rda   (rda),
    .rdb   (rdb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: a write lands in the architectural state first; an output then
  // shows whatever register it tracks, refreshed on capture or on a write
  // to the tracked register during a stall.
  task automatic model_edge(input logic r, input logic e, input logic [4:0] a,
                            input logic [4:0] b, input logic w, input logic [4:0] d,
                            input logic [31:0] wd);
    bit wrote;
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_rda = '0; m_rdb = '0; m_h1 = '0; m_h2 = '0;
      return;
    end
    wrote = w && (d != 5'd0);
    if (wrote) m_regs[d] = wd;
    if (e) begin
      m_h1 = a; m_h2 = b;
      m_rda = m_regs[a];
      m_rdb = m_regs[b];
    end else begin
      if (wrote && d == m_h1) m_rda = m_regs[m_h1];
      if (wrote && d == m_h2) m_rdb = m_regs[m_h2];
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [4:0] a,
                      input logic [4:0] b, input logic w, input logic [4:0] d,
                      input logic [31:0] wd);
    @(negedge clk);
    rst = r; en = e; rs1 = a; rs2 = b; wen = w; rd = d; wdata = wd;
    @(posedge clk);
    model_edge(r, e, a, b, w, d, wd);
    #1;
    chk("model_rda", rda, m_rda);
    chk("model_rdb", rdb, m_rdb);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rs1 = '0; rs2 = '0; wen = 1'b0; rd = '0; wdata = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'hx;
    m_rda = 32'hx; m_rdb = 32'hx; m_h1 = '0; m_h2 = '0;

    // Reset, then read x5/x0 and sweep every register.
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_rda", rda, 32'h0);
    chk("reset_rdb", rdb, 32'h0);
    step(0, 1, 5, 0, 0, 0, 0);
    chk("read_x5", rda, 32'h0);
    chk("read_x0", rdb, 32'h0);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 5'(i), 5'(31 - i), 0, 0, 0);
      chk("sweep_zero", rda, 32'h0);
    end

    // Write then read back.
    step(0, 0, 0, 0, 1, 3, 32'hDEADBEEF);
    step(0, 1, 3, 0, 0, 0, 0);
    chk("wr_rd_x3", rda, 32'hDEADBEEF);

    // Same-cycle bypass on both ports.
    step(0, 1, 7, 7, 1, 7, 32'h12345678);
    chk("bypass_a", rda, 32'h12345678);
    chk("bypass_b", rdb, 32'h12345678);

    // Write to x0 discarded, including same-cycle read of x0.
    step(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    step(0, 1, 0, 0, 1, 0, 32'hFFFFFFFF);
    chk("x0_rda", rda, 32'h0);
    chk("x0_rdb", rdb, 32'h0);

    // Stall refresh on held index.
    step(0, 0, 0, 0, 1, 9, 32'h1);
    step(0, 1, 3, 9, 0, 0, 0);
    chk("cap_rs2_9", rdb, 32'h1);
    step(0, 0, 0, 0, 1, 9, 32'hAA);
    chk("stall_rdb_upd", rdb, 32'hAA);
    chk("stall_rda_hold", rda, 32'hDEADBEEF);
    step(0, 0, 0, 0, 1, 10, 32'hBB);
    chk("stall_other_a", rda, 32'hDEADBEEF);
    chk("stall_other_b", rdb, 32'hAA);

    // Reset wins over a concurrent write and ends the stall.
    step(0, 0, 0, 0, 1, 4, 32'h44);
    step(0, 1, 4, 9, 0, 0, 0);
    chk("pre_rst_x4", rda, 32'h44);
    step(1, 1, 4, 4, 1, 4, 32'h55);
    chk("rst_rda", rda, 32'h0);
    chk("rst_rdb", rdb, 32'h0);
    step(0, 0, 0, 0, 1, 4, 32'h66);
    chk("held_x0_after_rst", rda, 32'h0);
    step(0, 1, 4, 9, 0, 0, 0);
    chk("x4_after_rst", rda, 32'h66);
    chk("x9_after_rst", rdb, 32'h0);

    // Randomized traffic; small index range to force hits and bypasses.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 2) != 0),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)),
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the register and operand width.
REQ-002 SHALL have parameter ADDR_W, default 5, the register index width (2**ADDR_W registers).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port en, input, 1, the operand-stage advance: 1 = capture new operands, 0 = stall.
REQ-006 SHALL have ports rs1 and rs2, input, ADDR_W each, the source register indices.
REQ-007 SHALL have port wen, input, 1, the writeback enable.
REQ-008 SHALL have port rd, input, ADDR_W, the writeback destination index.
REQ-009 SHALL have port wdata, input, DATA_W, the writeback data.
REQ-010 SHALL have ports rda and rdb, output, DATA_W each, the registered operands driven straight into the ALU rda/rdb inputs.

Function
REQ-011 SHALL hold 2**ADDR_W registers; x0 SHALL read as 0 always, and writes to x0 SHALL be discarded.
REQ-012 SHALL write wdata into register rd at the edge where wen=1 and rd!=0, independent of en.
REQ-013 SHALL, at an edge with en=1, load rda with the value of register rs1 and rdb with the value of register rs2; read latency is 1 cycle.
REQ-014 SHALL bypass a same-cycle write on capture: if en=1, wen=1, rd!=0 and rd==rs1, rda SHALL load wdata rather than the old register value; rdb likewise for rs2.
REQ-015 SHALL bypass both ports in the same cycle when rs1==rs2==rd (rd!=0).
REQ-016 SHALL latch rs1/rs2 into internal held indices at every en=1 edge.
REQ-017 SHALL, while en=0, hold rda/rdb, except that a write with wen=1, rd!=0 and rd equal to a held index SHALL update the matching output(s) with wdata at that edge, so a stalled operand is never stale.
REQ-018 SHALL return 0 on rda/rdb for a read of x0 even when wen=1 and rd=0 in the same cycle.
REQ-019 SHALL be purely registered on rda/rdb; there is no combinational path from any input to any output.

Reset
REQ-020 SHALL, at an edge with rst=1, clear all registers, rda, rdb and the held indices to 0; rst SHALL take priority over wen and en.
REQ-021 SHALL discard any write presented in the same cycle as rst=1; an in-progress stall SHALL end with rda=rdb=0 and held indices x0.

Verification
REQ-022 SHALL pass: rst 1 cycle, then en=1, rs1=5, rs2=0 -> rda=0, rdb=0 next cycle; every register reads 0.
REQ-023 SHALL pass: wen=1, rd=3, wdata=0xDEADBEEF; next cycle en=1, rs1=3 -> rda=0xDEADBEEF one cycle later.
REQ-024 SHALL pass: same cycle en=1, wen=1, rd=7, wdata=0x12345678, rs1=7, rs2=7 -> rda=rdb=0x12345678 next cycle (bypass).
REQ-025 SHALL pass: wen=1, rd=0, wdata=0xFFFFFFFF; then en=1, rs1=0 -> rda=0.
REQ-026 SHALL pass: capture rs2=9 (value 0x1), set en=0, then wen=1, rd=9, wdata=0xAA -> rdb=0xAA next cycle while rda stays unchanged; a write to rd=10 leaves both outputs unchanged.
REQ-027 SHALL pass: registers loaded, then rst=1 with wen=1, rd=4, wdata=0x55 -> rda=rdb=0 next cycle and reading register 4 returns 0.
